// File: rtl/ccc_cfg_sequencer.sv
// Fabric-side sequencer for CCC outputs B/C: holds bypass, applies new dividers,
// qualifies PLL lock with a filter/timeout/retry loop, then releases bypass.
module ccc_cfg_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_FILTER   = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       FAB_CLK,
    input  logic       M2F_RESET_N,
    input  logic       CFG_REQ,
    input  logic [6:0] CFG_FINDIV,
    input  logic [6:0] CFG_FBDIV,
    input  logic [4:0] CFG_OBDIV,
    input  logic [4:0] CFG_OCDIV,
    input  logic       CCC_LOCK,
    output logic       CFG_ACK,
    output logic [6:0] FINDIV,
    output logic [6:0] FBDIV,
    output logic [4:0] OBDIV,
    output logic [4:0] OCDIV,
    output logic       BYPASSB,
    output logic       BYPASSC,
    output logic       BUSY,
    output logic       DONE,
    output logic       LOCKED,
    output logic       ERR,
    output logic [1:0] RETRY_CNT
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] FILTER_MAX   = FW'(LOCK_FILTER);
    localparam logic [15:0]   TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_BYPASS, S_APPLY, S_WAIT_LOCK, S_RELEASE, S_FAIL
    } state_t;

    state_t          state;
    logic            lock_meta, lock_sync;
    logic [SW-1:0]   settle_cnt;
    logic [FW-1:0]   filter_cnt, filter_next;
    logic [15:0]     timeout_cnt;
    logic [6:0]      req_findiv, req_fbdiv;
    logic [4:0]      req_obdiv, req_ocdiv;
    logic            req_valid, filter_match, filter_full;

    assign req_valid = (CFG_FINDIV != '0) && (CFG_FBDIV != '0);

    // One filter serves both directions: runs of LOCK=1 while qualifying,
    // runs of LOCK=0 while monitoring for loss in IDLE.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        filter_match = (state == S_IDLE) ? !lock_sync : lock_sync;
        if (!filter_match)
            filter_next = '0;
        else if (filter_cnt == FILTER_MAX)
            filter_next = filter_cnt;
        else
            filter_next = filter_cnt + 1'b1;
        filter_full = (filter_next == FILTER_MAX);
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state       <= S_IDLE;
            lock_meta   <= 1'b0;
            lock_sync   <= 1'b0;
            settle_cnt  <= '0;
            filter_cnt  <= '0;
            timeout_cnt <= '0;
            req_findiv  <= 7'd6;
            req_fbdiv   <= 7'd6;
            req_obdiv   <= 5'd3;
            req_ocdiv   <= 5'd3;
            CFG_ACK     <= 1'b0;
            FINDIV      <= 7'd6;
            FBDIV       <= 7'd6;
            OBDIV       <= 5'd3;
            OCDIV       <= 5'd3;
            BYPASSB     <= 1'b1;
            BYPASSC     <= 1'b1;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            LOCKED      <= 1'b0;
            ERR         <= 1'b0;
            RETRY_CNT   <= 2'd0;
        end else begin
            lock_meta <= CCC_LOCK;
            lock_sync <= lock_meta;
            CFG_ACK   <= 1'b0;
            DONE      <= 1'b0;

            case (state)
                S_IDLE: begin
                    filter_cnt <= LOCKED ? filter_next : '0;
                    if (CFG_REQ && req_valid) begin
                        req_findiv <= CFG_FINDIV;
                        req_fbdiv  <= CFG_FBDIV;
                        req_obdiv  <= CFG_OBDIV;
                        req_ocdiv  <= CFG_OCDIV;
                        CFG_ACK    <= 1'b1;
                        ERR        <= 1'b0;
                        LOCKED     <= 1'b0;
                        RETRY_CNT  <= 2'd0;
                        BYPASSB    <= 1'b1;
                        BYPASSC    <= 1'b1;
                        BUSY       <= 1'b1;
                        settle_cnt <= '0;
                        state      <= S_BYPASS;
                    end else begin
                        if (CFG_REQ) begin
                            CFG_ACK <= 1'b1;
                            ERR     <= 1'b1;
                        end
                        if (LOCKED && filter_full) begin
                            LOCKED  <= 1'b0;
                            ERR     <= 1'b1;
                            BYPASSB <= 1'b1;
                            BYPASSC <= 1'b1;
                        end
                    end
                end

                S_BYPASS: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_APPLY;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                S_APPLY: begin
                    FINDIV      <= req_findiv;
                    FBDIV       <= req_fbdiv;
                    OBDIV       <= req_obdiv;
                    OCDIV       <= req_ocdiv;
                    filter_cnt  <= '0;
                    timeout_cnt <= '0;
                    state       <= S_WAIT_LOCK;
                end

                S_WAIT_LOCK: begin
                    filter_cnt <= filter_next;
                    if (filter_full) begin
                        settle_cnt <= '0;
                        state      <= S_RELEASE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        if (RETRY_CNT < RETRY_MAX) begin
                            RETRY_CNT  <= RETRY_CNT + 2'd1;
                            settle_cnt <= '0;
                            state      <= S_BYPASS;
                        end else begin
                            state <= S_FAIL;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                S_RELEASE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        BYPASSB    <= 1'b0;
                        BYPASSC    <= 1'b0;
                        LOCKED     <= 1'b1;
                        DONE       <= 1'b1;
                        BUSY       <= 1'b0;
                        filter_cnt <= '0;
                        state      <= S_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                S_FAIL: begin
                    ERR   <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccc_cfg_sequencer.sv
// Self-checking bench for ccc_cfg_sequencer: directed scenarios plus randomized
// requests/lock behaviour, compared every cycle against a behavioural model.
module tb_ccc_cfg_sequencer;

    localparam int SETTLE  = 16;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 100;
    localparam int RETRIES = 3;

    logic       FAB_CLK, M2F_RESET_N, CFG_REQ, CCC_LOCK;
    logic [6:0] CFG_FINDIV, CFG_FBDIV;
    logic [4:0] CFG_OBDIV, CFG_OCDIV;
    logic       CFG_ACK, BYPASSB, BYPASSC, BUSY, DONE, LOCKED, ERR;
    logic [6:0] FINDIV, FBDIV;
    logic [4:0] OBDIV, OCDIV;
    logic [1:0] RETRY_CNT;

    ccc_cfg_sequencer #(
        .SETTLE_CYCLES(SETTLE), .LOCK_FILTER(FILTER),
        .LOCK_TIMEOUT(TIMEOUT), .MAX_RETRIES(RETRIES)
    ) dut (
        .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N), .CFG_REQ(CFG_REQ),
        .CFG_FINDIV(CFG_FINDIV), .CFG_FBDIV(CFG_FBDIV),
        .CFG_OBDIV(CFG_OBDIV), .CFG_OCDIV(CFG_OCDIV), .CCC_LOCK(CCC_LOCK),
        .CFG_ACK(CFG_ACK), .FINDIV(FINDIV), .FBDIV(FBDIV), .OBDIV(OBDIV),
        .OCDIV(OCDIV), .BYPASSB(BYPASSB), .BYPASSC(BYPASSC), .BUSY(BUSY),
        .DONE(DONE), .LOCKED(LOCKED), .ERR(ERR), .RETRY_CNT(RETRY_CNT)
    );

    initial FAB_CLK = 1'b0;
    always #5 FAB_CLK = ~FAB_CLK;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_SETTLE_IN, M_APPLY, M_WAIT, M_SETTLE_OUT, M_FAIL} mphase_t;
    mphase_t m_phase;
    int      m_left, m_age;
    bit      m_p1, m_p2;
    bit      m_run[$];
    int      m_div[4], m_req[4];
    bit      m_ack, m_done, m_locked, m_err, m_byp;
    int      m_retry;

    // True when the most recent FILTER synchronised samples all equal v.
    function automatic bit tail_all(input bit v);
        if (m_run.size() < FILTER) return 0;
        for (int i = m_run.size() - FILTER; i < m_run.size(); i++)
            if (m_run[i] != v) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_left = 0; m_age = 0; m_p1 = 0; m_p2 = 0;
        m_run.delete();
        m_div = '{6, 6, 3, 3}; m_req = '{6, 6, 3, 3};
        m_ack = 0; m_done = 0; m_locked = 0; m_err = 0; m_byp = 1; m_retry = 0;
    endtask

    task automatic model_step();
        bit seen;
        seen = m_p2; m_p2 = m_p1; m_p1 = CCC_LOCK;
        m_ack = 0; m_done = 0;
        case (m_phase)
            M_IDLE: begin
                if (m_locked) m_run.push_back(seen); else m_run.delete();
                if (CFG_REQ && CFG_FINDIV != 0 && CFG_FBDIV != 0) begin
                    m_req = '{CFG_FINDIV, CFG_FBDIV, CFG_OBDIV, CFG_OCDIV};
                    m_ack = 1; m_err = 0; m_locked = 0; m_retry = 0; m_byp = 1;
                    m_phase = M_SETTLE_IN; m_left = SETTLE;
                end else begin
                    if (CFG_REQ) begin m_ack = 1; m_err = 1; end
                    if (m_locked && tail_all(0)) begin m_locked = 0; m_err = 1; m_byp = 1; end
                end
            end
            M_SETTLE_IN: begin
                m_left--;
                if (m_left == 0) m_phase = M_APPLY;
            end
            M_APPLY: begin
                m_div = m_req; m_run.delete(); m_age = 0; m_phase = M_WAIT;
            end
            M_WAIT: begin
                m_run.push_back(seen);
                if (tail_all(1)) begin
                    m_phase = M_SETTLE_OUT; m_left = SETTLE;
                end else begin
                    m_age++;
                    if (m_age == TIMEOUT) begin
                        if (m_retry < RETRIES) begin
                            m_retry++; m_phase = M_SETTLE_IN; m_left = SETTLE;
                        end else m_phase = M_FAIL;
                    end
                end
            end
            M_SETTLE_OUT: begin
                m_left--;
                if (m_left == 0) begin
                    m_byp = 0; m_locked = 1; m_done = 1; m_phase = M_IDLE; m_run.delete();
                end
            end
            default: begin
                m_err = 1; m_phase = M_IDLE;
            end
        endcase
    endtask

    initial model_reset();
    always @(negedge M2F_RESET_N) model_reset();
    always @(posedge FAB_CLK) if (M2F_RESET_N) model_step();

    always @(negedge FAB_CLK) begin
        if (DONE) done_seen++;
        if (cmp_en && M2F_RESET_N) begin
            check("ack",     CFG_ACK,   m_ack);
            check("done",    DONE,      m_done);
            check("busy",    BUSY,      m_phase != M_IDLE);
            check("locked",  LOCKED,    m_locked);
            check("err",     ERR,       m_err);
            check("bypassb", BYPASSB,   m_byp);
            check("bypassc", BYPASSC,   m_byp);
            check("findiv",  FINDIV,    m_div[0]);
            check("fbdiv",   FBDIV,     m_div[1]);
            check("obdiv",   OBDIV,     m_div[2]);
            check("ocdiv",   OCDIV,     m_div[3]);
            check("retry",   RETRY_CNT, m_retry);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge FAB_CLK);
    endtask

    task automatic send_req(input int fin, input int fb, input int ob, input int oc);
        CFG_REQ = 1; CFG_FINDIV = 7'(fin); CFG_FBDIV = 7'(fb);
        CFG_OBDIV = 5'(ob); CFG_OCDIV = 5'(oc);
        @(negedge FAB_CLK);
        check("ack_latency", CFG_ACK, 1);
        CFG_REQ = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (BUSY && n < budget) begin @(negedge FAB_CLK); n++; end
        if (BUSY) begin
            n_checks++; n_errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic wait_phase(input mphase_t p, input int budget, input string name);
        int n = 0;
        while (m_phase != p && n < budget) begin @(negedge FAB_CLK); n++; end
        if (m_phase != p) begin
            n_checks++; n_errors++;
            $display("FAIL %s: phase not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_findiv"}, FINDIV, 6);
        check({tag, "_fbdiv"},  FBDIV, 6);
        check({tag, "_obdiv"},  OBDIV, 3);
        check({tag, "_ocdiv"},  OCDIV, 3);
        check({tag, "_bypass"}, {BYPASSB, BYPASSC}, 2'b11);
        check({tag, "_flags"},  {CFG_ACK, DONE, BUSY, LOCKED, ERR}, 5'b0);
        check({tag, "_retry"},  RETRY_CNT, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int done0, acks;
        M2F_RESET_N = 0; CFG_REQ = 0; CCC_LOCK = 0;
        CFG_FINDIV = 0; CFG_FBDIV = 0; CFG_OBDIV = 0; CFG_OCDIV = 0;

        // 1: reset values
        #12;
        check_reset_values("reset");
        @(negedge FAB_CLK);
        M2F_RESET_N = 1;
        cmp_en = 1;
        tick(2);

        // 2: happy path, dividers change only after the bypass settle window
        send_req(2, 20, 4, 8);
        tick(SETTLE);
        check("hp_div_held", FINDIV, 6);
        check("hp_byp_held", BYPASSB, 1);
        tick(1);
        check("hp_div_applied", {FINDIV, FBDIV, OBDIV, OCDIV}, {7'd2, 7'd20, 5'd4, 5'd8});
        tick(4);
        CCC_LOCK = 1;
        done0 = done_seen;
        wait_idle(200, "hp_done");
        tick(1);
        check("hp_done_once", done_seen - done0, 1);
        check("hp_released", {BYPASSB, BYPASSC, LOCKED, ERR}, 4'b0010);

        // 6a: loss of lock while idle
        CCC_LOCK = 0;
        tick(FILTER + 4);
        check("loss_state", {LOCKED, ERR, BYPASSB, BYPASSC}, 4'b0111);

        // 3: chattering lock must not qualify
        send_req(3, 30, 2, 5);
        wait_phase(M_WAIT, 40, "chat_wait");
        repeat (3) begin
            CCC_LOCK = 1; tick(7);
            CCC_LOCK = 0; tick(1);
        end
        check("chat_no_release", {BUSY, BYPASSB, LOCKED}, 3'b110);
        CCC_LOCK = 1;
        done0 = done_seen;
        wait_idle(200, "chat_done");
        tick(1);
        check("chat_done_once", done_seen - done0, 1);
        check("chat_retry", RETRY_CNT, 0);

        // 5a: invalid request rejected, nothing else changes
        send_req(0, 9, 1, 1);
        tick(1);
        check("inv_err", {ERR, BUSY, LOCKED, BYPASSB}, 4'b1010);
        check("inv_divs", {FINDIV, FBDIV}, {7'd3, 7'd30});

        // 4: lock never asserts -> retries then fail
        done0 = done_seen;
        send_req(5, 40, 1, 2);
        CCC_LOCK = 0;
        wait_idle(1000, "to_idle");
        tick(1);
        check("to_retry", RETRY_CNT, 3);
        check("to_state", {ERR, BUSY, BYPASSB, BYPASSC, LOCKED}, 5'b10110);
        check("to_no_done", done_seen - done0, 0);
        check("to_div", FINDIV, 5);

        // 5b: request during WAIT_LOCK is ignored; then reset mid-WAIT_LOCK
        send_req(7, 11, 3, 4);
        check("acc_err_clr", ERR, 0);
        wait_phase(M_WAIT, 40, "rq_wait");
        CFG_REQ = 1; CFG_FINDIV = 9; CFG_FBDIV = 9;
        acks = 0;
        repeat (5) begin @(negedge FAB_CLK); if (CFG_ACK) acks++; end
        CFG_REQ = 0;
        check("busy_req_no_ack", acks, 0);
        #2 M2F_RESET_N = 0;
        #1 check_reset_values("midrst");
        tick(2);
        M2F_RESET_N = 1;
        tick(2);

        // randomized requests and lock behaviour
        for (int r = 0; r < 12; r++) begin
            int mode, fin, fb, n;
            mode = $urandom_range(0, 2);
            fin  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
            fb   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            send_req(fin, fb, $urandom_range(0, 31), $urandom_range(0, 31));
            n = 0;
            while (BUSY && n < 1000) begin
                CCC_LOCK = (mode == 2) ? 1'b1 :
                           (mode == 1) ? ($urandom_range(0, 9) != 0) : 1'b0;
                @(negedge FAB_CLK); n++;
            end
            CCC_LOCK = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 14));
        end

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
